// File: rtl/led_seq_if.sv
// Control/status bundle between the game FSM (master) and the LED sequence player (slave).
interface led_seq_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

  logic             push;
  logic [1:0]       push_color;
  logic             clear;
  logic             start;
  logic             busy;
  logic             done;
  logic             full;
  logic [LEN_W-1:0] seq_len;
  logic [3:0]       led;

  modport master (
    output push, push_color, clear, start,
    input  busy, done, full, seq_len, led
  );

  modport slave (
    input  push, push_color, clear, start,
    output busy, done, full, seq_len, led
  );
endinterface

// File: rtl/led_seq_player.sv
// Plays a stored Simon Says colour sequence on one-hot LEDs, paced by ticks from the slow LED clock.
// Optional LED_SEQ_FLASH_ALL_EN adds a final all-LEDs flash before done.
module led_seq_player #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ON_TICKS  = 3,
  parameter int unsigned OFF_TICKS = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      slowclk,
  led_seq_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

`ifdef LED_SEQ_FLASH_ALL_EN
  typedef enum logic [2:0] {IDLE, ON, GAP, FLASH, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ON, GAP, DONE} state_t;
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       led_q, led_d;
  logic             busy_q, done_q, full_q;
  logic             wr_en;
  logic             s1, s2, s3;
  logic             tick_c;
  logic [IDX_W-1:0] last_idx_c;
  logic [1:0]       seq_mem [DEPTH];

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  // slowclk is sampled as data; both of its edges become one-cycle ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slowclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_c     = s2 ^ s3;
  assign last_idx_c = IDX_W'(len_q - LEN_W'(1));

  // Colour storage; contents survive playback and reset
  always_ff @(posedge clk) begin
    if (wr_en) seq_mem[IDX_W'(len_q)] <= bus.push_color;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      len_q  <= '0;
      led_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      len_q  <= len_d;
      led_q  <= led_d;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      full_q <= (len_d == LEN_W'(DEPTH));
    end
  end

  // Next-state and next-output logic; clear overrides everything
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    len_d   = len_q;
    led_d   = led_q;
    wr_en   = 1'b0;

    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      len_d   = '0;
      led_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt_d = '0;
            idx_d = '0;
            if (len_q != '0) begin
              state_d = ON;
              led_d   = onehot(seq_mem[0]);
            end else begin
              state_d = DONE;
            end
          end else if (bus.push && !full_q) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_W'(1);
          end
        end
        ON: begin
          if (tick_c) begin
            if (cnt == CNT_W'(ON_TICKS - 1)) begin
              state_d = GAP;
              led_d   = '0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (tick_c) begin
            if (cnt == CNT_W'(OFF_TICKS - 1)) begin
              cnt_d = '0;
              if (idx == last_idx_c) begin
`ifdef LED_SEQ_FLASH_ALL_EN
                state_d = FLASH;
                led_d   = 4'b1111;
`else
                state_d = DONE;
`endif
              end else begin
                idx_d   = idx + IDX_W'(1);
                state_d = ON;
                led_d   = onehot(seq_mem[idx + IDX_W'(1)]);
              end
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end
        end
`ifdef LED_SEQ_FLASH_ALL_EN
        FLASH: begin
          if (tick_c) begin
            if (cnt == CNT_W'(ON_TICKS - 1)) begin
              state_d = DONE;
              led_d   = '0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end
        end
`endif
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.full    = full_q;
  assign bus.seq_len = len_q;
  assign bus.led     = led_q;

endmodule

// File: tb/tb_led_seq_player.sv
// Self-checking bench for led_seq_player: control vector table plus scoreboarded LED playback.
module tb_led_seq_player;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned ON_T  = 3;
  localparam int unsigned OFF_T = 1;
  localparam int          SP    = 8;   // clk cycles between slowclk toggles

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic slowclk = 1'b0;

  led_seq_if #(.DEPTH(DEPTH)) bus ();

  led_seq_player #(.DEPTH(DEPTH), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T)) dut (
    .clk     (clk),
    .rst     (rst),
    .slowclk (slowclk),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (SP) @(posedge clk);
      #1 slowclk = ~slowclk;
    end
  end

  typedef struct {
    logic [3:0] led;
    int         dur;   // cycles since previous LED change, -1 = don't care
  } exp_t;

  typedef struct {
    logic       p;
    logic [1:0] c;
    logic       cl;
    int         len;
    int         full;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] model_q[$];
  vec_t       vt[9];

  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         last_chg = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [3:0] last_led = 4'b0000;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] color_led(input logic [1:0] c);
    case (c)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // LED change monitor: every change is popped against the scoreboard
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst && bus.led !== last_led) begin
      if (exp_q.size() == 0) begin
        chk("led_unexpected_change", int'(bus.led), int'(last_led));
      end else begin
        mon_e = exp_q.pop_front();
        chk("led_value", int'(bus.led), int'(mon_e.led));
        if (mon_e.dur >= 0) chk("led_phase_cycles", cyc - last_chg, mon_e.dur);
      end
      last_led = bus.led;
      last_chg = cyc;
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      chk("busy_with_done", int'(bus.busy), 1);
    end
  end

  task automatic drive(input logic p, input logic [1:0] c, input logic cl, input logic st);
    bus.push       = p;
    bus.push_color = c;
    bus.clear      = cl;
    bus.start      = st;
    @(posedge clk);
    #1;
    bus.push  = 1'b0;
    bus.clear = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic push_col(input logic [1:0] c);
    drive(1'b1, c, 1'b0, 1'b0);
    if (model_q.size() < DEPTH) model_q.push_back(c);
  endtask

  task automatic clear_seq();
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    model_q.delete();
  endtask

  task automatic load_exp();
    for (int i = 0; i < model_q.size(); i++) begin
      exp_q.push_back('{color_led(model_q[i]), (i == 0) ? -1 : SP * OFF_T});
      exp_q.push_back('{4'b0000, (i == 0) ? -1 : SP * ON_T});
    end
`ifdef LED_SEQ_FLASH_ALL_EN
    exp_q.push_back('{4'b1111, SP * OFF_T});
    exp_q.push_back('{4'b0000, SP * ON_T});
`endif
  endtask

  // Start playback (optionally with a simultaneous push that must be dropped)
  task automatic play(input logic p, input logic [1:0] c);
    int d0;
    int n;
    int exp_delay;
    d0 = done_cnt;
    load_exp();
    drive(p, c, 1'b0, 1'b1);
    @(negedge clk);
    chk("busy_after_start", int'(bus.busy), 1);
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      chk("busy_during_play", int'(bus.busy), 1);
      n++;
    end
    if (n >= 3000) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("done_count", done_cnt, d0 + 1);
    chk("exp_queue_drained", exp_q.size(), 0);
`ifdef LED_SEQ_FLASH_ALL_EN
    exp_delay = 0;
`else
    exp_delay = SP * OFF_T;
`endif
    chk("done_after_last_led", done_cyc - last_chg, exp_delay);
    chk("seq_len_kept", int'(bus.seq_len), model_q.size());
  endtask

  initial begin
    int d0;
    int n;

    // control-path vectors applied in IDLE: {push, colour, clear, seq_len, full}
    vt[0] = '{1'b1, 2'd2, 1'b0, 1, 0};
    vt[1] = '{1'b1, 2'd0, 1'b0, 2, 0};
    vt[2] = '{1'b0, 2'd1, 1'b0, 2, 0};
    vt[3] = '{1'b1, 2'd3, 1'b0, 3, 0};
    vt[4] = '{1'b0, 2'd0, 1'b1, 0, 0};
    vt[5] = '{1'b1, 2'd1, 1'b1, 0, 0};
    vt[6] = '{1'b1, 2'd2, 1'b0, 1, 0};
    vt[7] = '{1'b1, 2'd0, 1'b0, 2, 0};
    vt[8] = '{1'b1, 2'd3, 1'b0, 3, 0};

    bus.push       = 1'b0;
    bus.push_color = 2'd0;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;

    // reset held while slowclk keeps toggling
    repeat (20) @(negedge clk);
    chk("rst_led", int'(bus.led), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_seq_len", int'(bus.seq_len), 0);
    chk("rst_full", int'(bus.full), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_led", int'(bus.led), 0);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_seq_len", int'(bus.seq_len), 0);
    chk("idle_no_done", done_cnt, 0);

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].p, vt[i].c, vt[i].cl, 1'b0);
      if (vt[i].cl) model_q.delete();
      else if (vt[i].p && model_q.size() < DEPTH) model_q.push_back(vt[i].c);
      @(negedge clk);
      chk($sformatf("vec%0d_seq_len", i), int'(bus.seq_len), vt[i].len);
      chk($sformatf("vec%0d_full", i), int'(bus.full), vt[i].full);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), 0);
      chk($sformatf("vec%0d_led", i), int'(bus.led), 0);
    end

    // sequence 2,0,3 played, then replayed unchanged
    play(1'b0, 2'd0);
    repeat (5) @(negedge clk);
    play(1'b0, 2'd0);

    // clear during the second colour's ON phase
    clear_seq();
    push_col(2'd2);
    push_col(2'd0);
    push_col(2'd3);
    exp_q.push_back('{4'b0100, -1});
    exp_q.push_back('{4'b0000, -1});
    exp_q.push_back('{4'b0001, SP * OFF_T});
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("second_colour_timeout", 0, 1);
    exp_q.push_back('{4'b0000, -1});
    d0 = done_cnt;
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    model_q.delete();
    @(negedge clk);
    chk("abort_led", int'(bus.led), 0);
    chk("abort_seq_len", int'(bus.seq_len), 0);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_exp_drained", exp_q.size(), 0);

    // start with an empty sequence
    d0 = done_cnt;
    drive(1'b0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("empty_done", int'(bus.done), 1);
    chk("empty_busy", int'(bus.busy), 1);
    chk("empty_led", int'(bus.led), 0);
    @(negedge clk);
    chk("empty_done_low", int'(bus.done), 0);
    chk("empty_busy_low", int'(bus.busy), 0);
    chk("empty_done_count", done_cnt, d0 + 1);

    // single colour 1; push of colour 3 together with start is dropped
    push_col(2'd1);
    play(1'b1, 2'd3);

    // fill to DEPTH and overflow by one
    clear_seq();
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_col(2'(i % 4));
      @(negedge clk);
      if (i == DEPTH - 1) begin
        chk("full_at_depth", int'(bus.full), 1);
        chk("len_at_depth", int'(bus.seq_len), DEPTH);
      end
      if (i == DEPTH) begin
        chk("full_after_extra", int'(bus.full), 1);
        chk("len_after_extra", int'(bus.seq_len), DEPTH);
      end
    end
    play(1'b0, 2'd0);

    // clear+start in IDLE: emptied, no playback
    d0 = done_cnt;
    drive(1'b0, 2'd0, 1'b1, 1'b1);
    model_q.delete();
    @(negedge clk);
    chk("clr_start_len", int'(bus.seq_len), 0);
    chk("clr_start_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    chk("clr_start_no_done", done_cnt, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
